data_memory_responder: RTL and testbench

- Responder side of the processor's data-memory interface.
- Accepts the read and write enables that the control unit raises during the MEM stage, and performs a word access with a parameterised wait-state count.
- Returns a one-cycle completion pulse so the sequencer can leave the MEM stage.
- Sits between the control unit/ALU result path and the write-back mux.

---
 rtl/dm_pkg.sv | 29 ++
 rtl/dm_storage_array.sv | 26 ++
 rtl/data_memory_responder.sv | 145 ++++++++++++++
 tb/tb_data_memory_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: state encoding,
// default parameters and the address validity helper.
package dm_pkg;

    localparam int unsigned DM_DATA_WIDTH_DEF  = 32;
    localparam int unsigned DM_ADDR_WIDTH_DEF  = 8;
    localparam int unsigned DM_WAIT_CYCLES_DEF = 2;
    localparam int unsigned DM_BYTE_ADDR_W     = 32;
    localparam int unsigned DM_CNT_W           = 4;

    localparam logic [DM_BYTE_ADDR_W-1:0] DM_ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        DM_IDLE = 2'b00,
        DM_WAIT = 2'b01,
        DM_RESP = 2'b10
    } dm_state_e;

    // A byte address is unusable if it is not word aligned or lies above the array.
    function automatic logic dm_addr_bad(input logic [DM_BYTE_ADDR_W-1:0] addr,
                                         input int unsigned addr_width);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr & DM_ALIGN_MASK) != '0;
        out_of_range = (addr >> (addr_width + 2)) != '0;
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/dm_storage_array.sv
// Word storage for the data-memory responder: synchronous write, combinational read.
module dm_storage_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data_c
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

    assign rd_data_c = mem_q[addr];

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one access per request rising edge, inserts
// WAIT_CYCLES wait states, then performs the access and pulses mem_ready.
module data_memory_responder
    import dm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DM_DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH  = DM_ADDR_WIDTH_DEF,
    parameter int unsigned WAIT_CYCLES = DM_WAIT_CYCLES_DEF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      sig_enable_data_memory_read,
    input  logic                      sig_enable_data_memory_write,
    input  logic [DM_BYTE_ADDR_W-1:0] address,
    input  logic [DATA_WIDTH-1:0]     write_data,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic                      mem_ready,
    output logic                      mem_busy,
    output logic                      addr_fault
);

    dm_state_e               state_q, state_d;
    logic [DM_CNT_W-1:0]     cnt_q, cnt_d;
    logic                    req_q, req_d;
    logic [ADDR_WIDTH-1:0]   word_q, word_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    is_wr_q, is_wr_d;
    logic                    fault_q, fault_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic                    mem_ready_q, mem_ready_d;
    logic                    mem_busy_q, mem_busy_d;
    logic                    addr_fault_q, addr_fault_d;

    logic                    req_c;
    logic                    accept_c;
    logic                    req_fault_c;
    logic                    wr_en_c;
    logic [DATA_WIDTH-1:0]   rd_data_c;

    dm_storage_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_storage (
        .clock     (clock),
        .wr_en     (wr_en_c),
        .addr      (word_q),
        .wr_data   (wdata_q),
        .rd_data_c (rd_data_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= DM_IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            word_q       <= '0;
            wdata_q      <= '0;
            is_wr_q      <= 1'b0;
            fault_q      <= 1'b0;
            read_data_q  <= '0;
            mem_ready_q  <= 1'b0;
            mem_busy_q   <= 1'b0;
            addr_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            word_q       <= word_d;
            wdata_q      <= wdata_d;
            is_wr_q      <= is_wr_d;
            fault_q      <= fault_d;
            read_data_q  <= read_data_d;
            mem_ready_q  <= mem_ready_d;
            mem_busy_q   <= mem_busy_d;
            addr_fault_q <= addr_fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        wdata_d      = wdata_q;
        is_wr_d      = is_wr_q;
        fault_d      = fault_q;
        read_data_d  = read_data_q;
        mem_ready_d  = 1'b0;
        addr_fault_d = 1'b0;
        wr_en_c      = 1'b0;

        req_c       = sig_enable_data_memory_read | sig_enable_data_memory_write;
        req_d       = req_c;
        // mem_busy_q also covers the completion cycle, so a rise there is dropped.
        accept_c    = req_c & ~req_q & ~mem_busy_q;
        req_fault_c = (sig_enable_data_memory_read & sig_enable_data_memory_write)
                    | dm_addr_bad(address, ADDR_WIDTH);

        unique case (state_q)
            DM_IDLE: begin
                if (accept_c) begin
                    word_d  = address[ADDR_WIDTH+1:2];
                    wdata_d = write_data;
                    is_wr_d = sig_enable_data_memory_write;
                    fault_d = req_fault_c;
                    cnt_d   = DM_CNT_W'(WAIT_CYCLES);
                    if (req_fault_c || (WAIT_CYCLES == 0)) begin
                        state_d = DM_RESP;
                    end else begin
                        state_d = DM_WAIT;
                    end
                end
            end
            DM_WAIT: begin
                cnt_d = cnt_q - DM_CNT_W'(1);
                if (cnt_q <= DM_CNT_W'(1)) begin
                    state_d = DM_RESP;
                end
            end
            DM_RESP: begin
                mem_ready_d  = 1'b1;
                addr_fault_d = fault_q;
                if (!fault_q) begin
                    if (is_wr_q) begin
                        wr_en_c = 1'b1;
                    end else begin
                        read_data_d = rd_data_c;
                    end
                end
                cnt_d   = '0;
                state_d = DM_IDLE;
            end
            default: begin
                state_d = DM_IDLE;
            end
        endcase

        mem_busy_d = (state_d != DM_IDLE) || (state_q == DM_RESP);
    end

    assign read_data  = read_data_q;
    assign mem_ready  = mem_ready_q;
    assign mem_busy   = mem_busy_q;
    assign addr_fault = addr_fault_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: a WAIT_CYCLES=2 and a
// WAIT_CYCLES=0 instance driven with directed and random accesses.
module tb_data_memory_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        reset_n;
    int          cyc;
    int          checks;
    int          errors;

    logic        rd0, wr0, rd1, wr1;
    logic [31:0] addr0, wd0, addr1, wd1;
    logic [31:0] rdata0, rdata1;
    logic        rdy0, busy0, flt0, rdy1, busy1, flt1;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;

    logic [31:0] mdl [2][256];
    logic [31:0] last_rd [2];

    data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .sig_enable_data_memory_read(rd0), .sig_enable_data_memory_write(wr0),
        .address(addr0), .write_data(wd0), .read_data(rdata0),
        .mem_ready(rdy0), .mem_busy(busy0), .addr_fault(flt0)
    );

    data_memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .sig_enable_data_memory_read(rd1), .sig_enable_data_memory_write(wr1),
        .address(addr1), .write_data(wd1), .read_data(rdata1),
        .mem_ready(rdy1), .mem_busy(busy1), .addr_fault(flt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitors: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && rdy0) begin
            if (q0.size() == 0) begin
                chk("d0_unexpected_ready", 32'(rdy0), 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("d0_read_data", rdata0, e0.rdata);
                chk("d0_addr_fault", 32'(flt0), 32'(e0.fault));
                chk("d0_ready_cycle", 32'(cyc), 32'(e0.cyc));
            end
        end
        if (reset_n && flt0 && !rdy0) chk("d0_fault_without_ready", 32'(flt0), 32'd0);
    end

    always @(negedge clock) begin
        if (reset_n && rdy1) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_ready", 32'(rdy1), 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("d1_read_data", rdata1, e1.rdata);
                chk("d1_addr_fault", 32'(flt1), 32'(e1.fault));
                chk("d1_ready_cycle", 32'(cyc), 32'(e1.cyc));
            end
        end
        if (reset_n && flt1 && !rdy1) chk("d1_fault_without_ready", 32'(flt1), 32'd0);
    end

    task automatic set_req(input int d, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] dat);
        if (d == 0) begin
            rd0 = rd; wr0 = wr; addr0 = a; wd0 = dat;
        end else begin
            rd1 = rd; wr1 = wr; addr1 = a; wd1 = dat;
        end
    endtask

    // One access: update the model, queue the expected response, hold the
    // request for 'hold' cycles (then scramble inputs), and count busy cycles.
    task automatic access(input int d, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] dat, input int hold);
        int   lat;
        int   busy_n;
        bit   flt;
        exp_t e;
        lat = (d == 0) ? 2 : 0;
        flt = (rd && wr) || (a % 4 != 0) || (a >= 32'h400);
        @(negedge clock);
        if (flt) begin
            lat = 0;
        end else if (wr) begin
            mdl[d][a / 4] = dat;
        end else begin
            last_rd[d] = mdl[d][a / 4];
        end
        e.rdata = last_rd[d];
        e.fault = flt;
        e.cyc   = cyc + lat + 2;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        set_req(d, rd, wr, a, dat);
        busy_n = 0;
        for (int k = 0; k < hold + lat + 8; k++) begin
            @(negedge clock);
            if ((d == 0) ? busy0 : busy1) busy_n++;
            if (k == hold - 1) set_req(d, 1'b0, 1'b0, $urandom, $urandom);
        end
        chk((d == 0) ? "d0_busy_cycles" : "d1_busy_cycles", 32'(busy_n), 32'(lat + 2));
        chk((d == 0) ? "d0_pending_left" : "d1_pending_left",
            32'((d == 0) ? q0.size() : q1.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_d0_read_data"}, rdata0, 32'd0);
        chk({nm, "_d0_flags"}, {29'd0, rdy0, busy0, flt0}, 32'd0);
        chk({nm, "_d1_read_data"}, rdata1, 32'd0);
        chk({nm, "_d1_flags"}, {29'd0, rdy1, busy1, flt1}, 32'd0);
    endtask

    // Write to 0x20, then reset k cycles after acceptance; the write must vanish.
    task automatic reset_mid(input int k, input logic [31:0] dat);
        @(negedge clock);
        set_req(0, 1'b0, 1'b1, 32'h20, dat);
        repeat (k) @(negedge clock);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1);
    endtask

    function automatic int pick_word();
        int r;
        r = int'($urandom_range(0, 17));
        if (r < 16) return r;
        return (r == 16) ? 63 : 255;
    endfunction

    initial begin
        int   w;
        int   op;
        int   d;
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Give every word the random phase may read a known value.
        for (int i = 0; i < 18; i++) begin
            w = (i < 16) ? i : ((i == 16) ? 63 : 255);
            access(0, 1'b0, 1'b1, 32'(w * 4), $urandom, 1);
            access(1, 1'b0, 1'b1, 32'(w * 4), $urandom, 1);
        end

        access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1);
        access(0, 1'b0, 1'b1, 32'h4, 32'h1111_2222, 1);
        access(0, 1'b1, 1'b0, 32'h4, 32'h0, 8);
        access(0, 1'b0, 1'b1, 32'h6, 32'h0000_1234, 1);
        access(0, 1'b1, 1'b0, 32'h4, 32'h0, 1);
        access(0, 1'b1, 1'b0, 32'h400, 32'h0, 1);
        access(0, 1'b1, 1'b1, 32'h8, 32'h5555_AAAA, 1);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1);
        access(0, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 1);
        reset_mid(1, 32'hBAD0_0001);
        reset_mid(2, 32'hBAD0_0002);
        reset_mid(3, 32'hBAD0_0003);

        access(1, 1'b0, 1'b1, 32'hFC, 32'hA5A5_A5A5, 1);
        access(1, 1'b1, 1'b0, 32'hFC, 32'h0, 1);
        access(1, 1'b0, 1'b1, 32'h3FC, 32'h5A5A_5A5A, 2);
        access(1, 1'b1, 1'b0, 32'h3FC, 32'h0, 3);
        access(1, 1'b1, 1'b0, 32'h402, 32'h0, 1);

        for (int i = 0; i < 60; i++) begin
            d  = i % 2;
            w  = pick_word();
            op = int'($urandom_range(0, 9));
            if (op < 4)
                access(d, 1'b0, 1'b1, 32'(w * 4), $urandom, int'($urandom_range(1, 4)));
            else if (op < 7)
                access(d, 1'b1, 1'b0, 32'(w * 4), 32'h0, int'($urandom_range(1, 4)));
            else if (op == 7)
                access(d, 1'($urandom_range(0, 1)), 1'b1,
                       32'(w * 4 + int'($urandom_range(1, 3))), $urandom, 1);
            else if (op == 8)
                access(d, 1'b1, 1'b0, 32'(w * 4) | (32'h1 << $urandom_range(10, 31)), 32'h0, 2);
            else
                access(d, 1'b1, 1'b1, 32'(w * 4), $urandom, 1);
        end

        repeat (5) @(negedge clock);
        chk("final_queue_d0", 32'(q0.size()), 32'd0);
        chk("final_queue_d1", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
